// File: rtl/run_length_detector.sv
// Run-length detector: counts qualifying w=1 samples, flags a hit when THRESHOLD
// samples are reached and keeps a wrapping tally of hits.
module run_length_detector #(
    parameter int CNT_WIDTH    = 3,
    parameter int THRESHOLD    = 4,
    parameter int MODE         = 0,
    parameter int AUTO_RESTART = 1,
    parameter int HIT_WIDTH    = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 clear,
    input  logic                 w,
    output logic                 count,
    output logic [CNT_WIDTH-1:0] state,
    output logic [HIT_WIDTH-1:0] hit_count
);

    if (THRESHOLD < 1 || THRESHOLD > (2 ** CNT_WIDTH) - 1) begin : g_bad_threshold
        $error("run_length_detector: THRESHOLD out of range 1..2**CNT_WIDTH-1");
    end

    localparam logic [CNT_WIDTH-1:0] THR        = CNT_WIDTH'(THRESHOLD);
    localparam logic                 RESTART    = (AUTO_RESTART != 0);
    localparam logic                 CUMULATIVE = (MODE != 0);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        COUNT = 2'b01,
        LOCK  = 2'b10
    } fsm_t;

    fsm_t                 fsm_r, fsm_s;
    logic [CNT_WIDTH-1:0] run_r, run_s, nxt_s;
    logic [HIT_WIDTH-1:0] hit_r, hit_s;
    logic                 count_r, count_s;

    // Next-state, next-run, hit tally and hit flag
    always_comb begin
        fsm_s   = fsm_r;
        run_s   = run_r;
        hit_s   = hit_r;
        count_s = 1'b0;
        nxt_s   = run_r + CNT_WIDTH'(1'b1);
        if (!enable) begin
            fsm_s = fsm_r;
            run_s = run_r;
        end else if (clear) begin
            run_s = {CNT_WIDTH{1'b0}};
            fsm_s = IDLE;
        end else if (w) begin
            case (fsm_r)
                IDLE, COUNT: begin
                    if (nxt_s == THR) begin
                        count_s = 1'b1;
                        hit_s   = hit_r + HIT_WIDTH'(1'b1);
                        if (RESTART) begin
                            run_s = {CNT_WIDTH{1'b0}};
                            fsm_s = IDLE;
                        end else begin
                            run_s = THR;
                            fsm_s = LOCK;
                        end
                    end else begin
                        run_s = nxt_s;
                        fsm_s = COUNT;
                    end
                end
                LOCK: begin
                    run_s   = THR;
                    count_s = 1'b1;
                end
                default: begin
                    run_s = {CNT_WIDTH{1'b0}};
                    fsm_s = IDLE;
                end
            endcase
        end else if (!CUMULATIVE) begin
            run_s = {CNT_WIDTH{1'b0}};
            fsm_s = IDLE;
        end else begin
            // Cumulative mode keeps the run (and any LOCK) across w=0 gaps
            run_s = run_r;
            fsm_s = fsm_r;
        end
    end

    // State, run, tally and hit-flag registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fsm_r   <= IDLE;
            run_r   <= {CNT_WIDTH{1'b0}};
            hit_r   <= {HIT_WIDTH{1'b0}};
            count_r <= 1'b0;
        end else begin
            fsm_r   <= fsm_s;
            run_r   <= run_s;
            hit_r   <= hit_s;
            count_r <= count_s;
        end
    end

    assign count     = count_r;
    assign state     = run_r;
    assign hit_count = hit_r;

endmodule

// File: tb/tb_run_length_detector.sv
// Directed bench for run_length_detector: four parameter variants share one
// stimulus bus; each scenario checks the variant it targets.
module tb_run_length_detector;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       clear = 1'b0;
    logic       w = 1'b0;

    logic       cnt_d, cnt_c, cnt_l, cnt_t;
    logic [2:0] st_d, st_c, st_l, st_t;
    logic [3:0] hit_d, hit_c, hit_l;
    logic [1:0] hit_t;

    int errors = 0;
    int checks = 0;

    run_length_detector dut_def (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear), .w(w),
        .count(cnt_d), .state(st_d), .hit_count(hit_d)
    );

    run_length_detector #(.MODE(1)) dut_cum (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear), .w(w),
        .count(cnt_c), .state(st_c), .hit_count(hit_c)
    );

    run_length_detector #(.AUTO_RESTART(0)) dut_lock (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear), .w(w),
        .count(cnt_l), .state(st_l), .hit_count(hit_l)
    );

    run_length_detector #(.THRESHOLD(1), .HIT_WIDTH(2)) dut_t1 (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear), .w(w),
        .count(cnt_t), .state(st_t), .hit_count(hit_t)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; clear = 1'b0; w = 1'b1;
        tick();
        checks++;
        if ({cnt_d, st_d, hit_d} !== 8'd0) begin
            errors++; $display("FAIL reset_def got %b exp 0", {cnt_d, st_d, hit_d});
        end
        checks++;
        if ({cnt_c, st_c, hit_c, cnt_l, st_l, hit_l} !== 16'd0) begin
            errors++; $display("FAIL reset_cum_lock got %b exp 0", {cnt_c, st_c, hit_c, cnt_l, st_l, hit_l});
        end
        checks++;
        if ({cnt_t, st_t, hit_t} !== 6'd0) begin
            errors++; $display("FAIL reset_t1 got %b exp 0", {cnt_t, st_t, hit_t});
        end
        reset = 1'b0;
    endtask

    task automatic test_auto_restart();
        int exp_st[8];
        int exp_cn[8];
        exp_st = '{1, 2, 3, 0, 1, 2, 3, 0};
        exp_cn = '{0, 0, 0, 1, 0, 0, 0, 1};
        apply_reset();
        enable = 1'b1; clear = 1'b0; w = 1'b0;
        tick();
        checks++;
        if (st_d !== 3'd0) begin
            errors++; $display("FAIL ar_idle state got %0d exp 0", st_d);
        end
        w = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (st_d !== 3'(exp_st[i]) || cnt_d !== 1'(exp_cn[i])) begin
                errors++;
                $display("FAIL ar_run[%0d] state/count got %0d/%0d exp %0d/%0d",
                         i, st_d, cnt_d, exp_st[i], exp_cn[i]);
            end
        end
        checks++;
        if (hit_d !== 4'd2) begin
            errors++; $display("FAIL ar_hits got %0d exp 2", hit_d);
        end
    endtask

    task automatic test_consecutive();
        int pat[5];
        int exp_st[5];
        pat    = '{1, 1, 1, 0, 1};
        exp_st = '{1, 2, 3, 0, 1};
        apply_reset();
        enable = 1'b1; clear = 1'b0;
        for (int i = 0; i < 5; i++) begin
            w = 1'(pat[i]);
            tick();
            checks++;
            if (st_d !== 3'(exp_st[i]) || cnt_d !== 1'b0) begin
                errors++;
                $display("FAIL consec[%0d] state/count got %0d/%0d exp %0d/0",
                         i, st_d, cnt_d, exp_st[i]);
            end
        end
        checks++;
        if (hit_d !== 4'd0) begin
            errors++; $display("FAIL consec_hits got %0d exp 0", hit_d);
        end
    endtask

    task automatic test_cumulative();
        int pat[6];
        int exp_st[6];
        int exp_cn[6];
        pat    = '{1, 0, 1, 0, 1, 1};
        exp_st = '{1, 1, 2, 2, 3, 0};
        exp_cn = '{0, 0, 0, 0, 0, 1};
        apply_reset();
        enable = 1'b1; clear = 1'b0;
        for (int i = 0; i < 6; i++) begin
            w = 1'(pat[i]);
            tick();
            checks++;
            if (st_c !== 3'(exp_st[i]) || cnt_c !== 1'(exp_cn[i])) begin
                errors++;
                $display("FAIL cumul[%0d] state/count got %0d/%0d exp %0d/%0d",
                         i, st_c, cnt_c, exp_st[i], exp_cn[i]);
            end
        end
        checks++;
        if (hit_c !== 4'd1) begin
            errors++; $display("FAIL cumul_hits got %0d exp 1", hit_c);
        end
    endtask

    task automatic test_lock();
        int exp_st[6];
        int exp_cn[6];
        exp_st = '{1, 2, 3, 4, 4, 4};
        exp_cn = '{0, 0, 0, 1, 1, 1};
        apply_reset();
        enable = 1'b1; clear = 1'b0; w = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (st_l !== 3'(exp_st[i]) || cnt_l !== 1'(exp_cn[i])) begin
                errors++;
                $display("FAIL lock[%0d] state/count got %0d/%0d exp %0d/%0d",
                         i, st_l, cnt_l, exp_st[i], exp_cn[i]);
            end
        end
        checks++;
        if (hit_l !== 4'd1) begin
            errors++; $display("FAIL lock_hits got %0d exp 1", hit_l);
        end
        enable = 1'b0;
        tick();
        checks++;
        if (st_l !== 3'd4 || cnt_l !== 1'b0) begin
            errors++; $display("FAIL lock_freeze state/count got %0d/%0d exp 4/0", st_l, cnt_l);
        end
        enable = 1'b1; w = 1'b0;
        tick();
        checks++;
        if (st_l !== 3'd0 || cnt_l !== 1'b0 || hit_l !== 4'd1) begin
            errors++;
            $display("FAIL lock_exit state/count/hits got %0d/%0d/%0d exp 0/0/1", st_l, cnt_l, hit_l);
        end
    endtask

    task automatic test_enable_clear();
        apply_reset();
        enable = 1'b1; clear = 1'b0; w = 1'b1;
        tick();
        tick();
        checks++;
        if (st_d !== 3'd2) begin
            errors++; $display("FAIL en_setup state got %0d exp 2", st_d);
        end
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (st_d !== 3'd2 || cnt_d !== 1'b0) begin
                errors++; $display("FAIL en_hold[%0d] state/count got %0d/%0d exp 2/0", i, st_d, cnt_d);
            end
        end
        enable = 1'b1; clear = 1'b1;
        tick();
        checks++;
        if (st_d !== 3'd0 || cnt_d !== 1'b0) begin
            errors++; $display("FAIL clear state/count got %0d/%0d exp 0/0", st_d, cnt_d);
        end
        clear = 1'b0;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (cnt_t !== 1'b1 || st_t !== 3'd0 || hit_t !== 2'((i + 1) % 4)) begin
                errors++;
                $display("FAIL t1[%0d] count/state/hits got %0d/%0d/%0d exp 1/0/%0d",
                         i, cnt_t, st_t, hit_t, (i + 1) % 4);
            end
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        enable = 1'b1; clear = 1'b0; w = 1'b1;
        for (int i = 0; i < 23; i++) tick();
        checks++;
        if (st_d !== 3'd3 || hit_d !== 4'd5) begin
            errors++; $display("FAIL ares_setup state/hits got %0d/%0d exp 3/5", st_d, hit_d);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (st_d !== 3'd0 || hit_d !== 4'd0 || cnt_d !== 1'b0) begin
            errors++;
            $display("FAIL ares_async state/hits/count got %0d/%0d/%0d exp 0/0/0", st_d, hit_d, cnt_d);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (st_d !== 3'd1 || hit_d !== 4'd0) begin
            errors++; $display("FAIL ares_release state/hits got %0d/%0d exp 1/0", st_d, hit_d);
        end
    endtask

    initial begin
        test_reset();
        test_auto_restart();
        test_consecutive();
        test_cumulative();
        test_lock();
        test_enable_clear();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
